// File: rtl/scan_test_pkg.sv
// Shared types and defaults for the scan-test result path.
package scan_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int          SIG_W_DEF   = 16;
  localparam int          CNT_W_DEF   = 20;
  localparam int          TIMEOUT_DEF = 4096;
  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam logic [15:0] MISR_SEED   = 16'hFFFF;

endpackage

// File: rtl/misr_serial.sv
// Serial-input MISR: shifts left, folding the chain bit into the MSB feedback.
module misr_serial #(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic b);
    logic fb;
    fb = s[SIG_W-1] ^ b;
    return {s[SIG_W-2:0], 1'b0} ^ (fb ? POLY : {SIG_W{1'b0}});
  endfunction

  // Load wins over a shift so a re-arm always starts from the seed.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = misr_next(sig_q, din);
    end else begin
      sig_d = sig_q;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/scan_result_collector.sv
// Compacts the scan-out stream of one pattern, counts shifted bits and
// produces a pass/fail verdict against the expected signature and ScanNum.
module scan_result_collector
  import scan_test_pkg::*;
#(
  parameter int               SIG_W   = SIG_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(CRC16_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(MISR_SEED),
  parameter int               TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] ScanNum,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             test_se,
  input  logic             shift_strobe,
  input  logic             scan_out,
  input  logic             scan_done,
  output logic             busy,
  output logic [SIG_W-1:0] sig,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             result_valid,
  output logic             pass,
  output logic             cnt_err,
  output logic             timeout
);

  // TIMEOUT must be at least 2; the counter never exceeds TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             done_prev_q;
  logic [CNT_W-1:0] num_l_q, num_l_d;
  logic [SIG_W-1:0] exp_l_q, exp_l_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             pass_q, pass_d;
  logic             cnt_err_q, cnt_err_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;

  logic             collecting_s;
  logic             accept_s;
  logic             done_rise_s;
  logic             wd_expire_s;
  logic             cnt_mismatch_s;
  logic [SIG_W-1:0] sig_s;

  assign collecting_s   = (state_q == ST_ARMED) || (state_q == ST_SHIFT);
  assign accept_s       = collecting_s && shift_strobe && test_se;
  assign done_rise_s    = scan_done && !done_prev_q;
  assign wd_expire_s    = collecting_s && !accept_s && (wdog_q == WD_LAST);
  assign cnt_mismatch_s = (bit_cnt_q != num_l_q);

  misr_serial #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start),
    .seed (SEED),
    .en   (accept_s && !start),
    .din  (scan_out),
    .sig  (sig_s)
  );

  // Next-state, counters, watchdog and verdict.
  always_comb begin
    state_d   = state_q;
    num_l_d   = num_l_q;
    exp_l_d   = exp_l_q;
    bit_cnt_d = bit_cnt_q;
    wdog_d    = wdog_q;
    pass_d    = pass_q;
    cnt_err_d = cnt_err_q;
    timeout_d = timeout_q;
    if (start) begin
      state_d   = ST_ARMED;
      num_l_d   = ScanNum;
      exp_l_d   = exp_sig;
      bit_cnt_d = {CNT_W{1'b0}};
      wdog_d    = {WD_W{1'b0}};
      pass_d    = 1'b0;
      cnt_err_d = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED, ST_SHIFT: begin
          if (accept_s) begin
            wdog_d = {WD_W{1'b0}};
            if (bit_cnt_q != {CNT_W{1'b1}}) begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
          if (wd_expire_s) begin
            timeout_d = 1'b1;
          end else begin
            timeout_d = timeout_q;
          end
          if (done_rise_s || wd_expire_s) begin
            state_d = ST_CHECK;
          end else if ((state_q == ST_ARMED) && test_se) begin
            state_d = ST_SHIFT;
          end else begin
            state_d = state_q;
          end
        end
        ST_CHECK: begin
          cnt_err_d = cnt_mismatch_s;
          pass_d    = (sig_s == exp_l_q) && !cnt_mismatch_s && !timeout_q;
          state_d   = ST_DONE;
        end
        ST_IDLE, ST_DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_ARMED) || (state_d == ST_SHIFT) || (state_d == ST_CHECK);
    rv_d   = (state_d == ST_DONE);
  end

  // State and datapath registers; done_prev tracks scan_done in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_prev_q <= 1'b0;
      num_l_q     <= {CNT_W{1'b0}};
      exp_l_q     <= {SIG_W{1'b0}};
      bit_cnt_q   <= {CNT_W{1'b0}};
      wdog_q      <= {WD_W{1'b0}};
      pass_q      <= 1'b0;
      cnt_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= scan_done;
      num_l_q     <= num_l_d;
      exp_l_q     <= exp_l_d;
      bit_cnt_q   <= bit_cnt_d;
      wdog_q      <= wdog_d;
      pass_q      <= pass_d;
      cnt_err_q   <= cnt_err_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      rv_q        <= rv_d;
    end
  end

  assign busy         = busy_q;
  assign sig          = sig_s;
  assign bit_cnt      = bit_cnt_q;
  assign result_valid = rv_q;
  assign pass         = pass_q;
  assign cnt_err      = cnt_err_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_scan_result_collector.sv
// Directed bench with a verdict scoreboard; a second default-parameter
// instance shares the stimulus to exercise the all-ones seed.
module tb_scan_result_collector;
  localparam int SIG_W = 16;
  localparam int CNT_W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, test_se = 1'b0, shift_strobe = 1'b0;
  logic scan_out = 1'b0, scan_done = 1'b0;
  logic [CNT_W-1:0] ScanNum = '0;
  logic [SIG_W-1:0] exp_sig = '0;

  logic busy, result_valid, pass, cnt_err, timeout;
  logic [SIG_W-1:0] sig;
  logic [CNT_W-1:0] bit_cnt;
  logic d_busy, d_result_valid, d_pass, d_cnt_err, d_timeout;
  logic [SIG_W-1:0] d_sig;
  logic [CNT_W-1:0] d_bit_cnt;

  scan_result_collector #(.SEED(16'h0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .ScanNum(ScanNum), .exp_sig(exp_sig),
    .test_se(test_se), .shift_strobe(shift_strobe), .scan_out(scan_out),
    .scan_done(scan_done), .busy(busy), .sig(sig), .bit_cnt(bit_cnt),
    .result_valid(result_valid), .pass(pass), .cnt_err(cnt_err), .timeout(timeout)
  );

  scan_result_collector dut_def (
    .clk(clk), .rst(rst), .start(start), .ScanNum(ScanNum), .exp_sig(exp_sig),
    .test_se(test_se), .shift_strobe(shift_strobe), .scan_out(scan_out),
    .scan_done(scan_done), .busy(d_busy), .sig(d_sig), .bit_cnt(d_bit_cnt),
    .result_valid(d_result_valid), .pass(d_pass), .cnt_err(d_cnt_err), .timeout(d_timeout)
  );

  typedef struct packed {
    logic             pass;
    logic             cnt_err;
    logic             timeout;
    logic [CNT_W-1:0] cnt;
    logic [SIG_W-1:0] sig;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [SIG_W-1:0] m_sig, m_exp;
  logic [CNT_W-1:0] m_cnt, m_num;

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
    logic fb;
    fb = s[15] ^ b;
    return (s << 1) ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] sig_of(input logic [15:0] s0, input logic [15:0] bits, input int n);
    logic [15:0] s;
    s = s0;
    for (int i = 0; i < n; i++) s = misr_step(s, bits[i]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [CNT_W-1:0] n, input logic [SIG_W-1:0] e);
    start = 1'b1; ScanNum = n; exp_sig = e;
    m_sig = 16'h0000; m_cnt = '0; m_num = n; m_exp = e;
    step();
    start = 1'b0;
  endtask

  task automatic shift(input logic b, input logic se);
    test_se = se; shift_strobe = 1'b1; scan_out = b;
    step();
    shift_strobe = 1'b0;
    if (se) begin
      m_sig = misr_step(m_sig, b);
      m_cnt = m_cnt + 20'd1;
    end
  endtask

  task automatic push_expect(input logic to);
    exp_t e;
    e.sig     = m_sig;
    e.cnt     = m_cnt;
    e.timeout = to;
    e.cnt_err = (m_cnt != m_num);
    e.pass    = (m_sig == m_exp) && (m_cnt == m_num) && !to;
    sb.push_back(e);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    chk({tag, "_rv"}, 32'(result_valid), 32'd1);
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
      chk({tag, "_cnt_err"}, 32'(cnt_err), 32'(e.cnt_err));
      chk({tag, "_timeout"}, 32'(timeout), 32'(e.timeout));
      chk({tag, "_bit_cnt"}, 32'(bit_cnt), 32'(e.cnt));
      chk({tag, "_sig"}, 32'(sig), 32'(e.sig));
    end
  endtask

  // Raise scan_done (optionally with a final strobe) and expect DONE two edges later.
  task automatic end_pattern(input string tag, input logic with_bit, input logic b);
    int cyc;
    scan_done = 1'b1;
    if (with_bit) begin
      test_se = 1'b1; shift_strobe = 1'b1; scan_out = b;
      m_sig = misr_step(m_sig, b);
      m_cnt = m_cnt + 20'd1;
    end
    push_expect(1'b0);
    step();
    shift_strobe = 1'b0;
    chk({tag, "_check_rv"}, 32'(result_valid), 32'd0);
    step();
    cyc = 0;
    while (!result_valid && cyc < 8) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd0);
    collect(tag);
    scan_done = 1'b0;
    test_se = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    logic [15:0] e;

    rst = 1'b1;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sig", 32'(sig), 32'h0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_def_sig", 32'(d_sig), 32'hFFFF);
    rst = 1'b0;
    step();

    // 1: eight zero bits against a zero seed
    arm(20'd8, 16'h0000);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_armed_cnt", 32'(bit_cnt), 32'd0);
    for (int i = 0; i < 8; i++) shift(1'b0, 1'b1);
    chk("t1_bit_cnt", 32'(bit_cnt), 32'd8);
    end_pattern("t1", 1'b0, 1'b0);

    // 2: single one bit, matching and off-by-one signature
    arm(20'd1, 16'h1021);
    shift(1'b1, 1'b1);
    chk("t2_sig", 32'(sig), 32'h1021);
    chk("t2_def_sig", 32'(d_sig), 32'hFFFE);
    end_pattern("t2a", 1'b0, 1'b0);
    arm(20'd1, 16'h1020);
    shift(1'b1, 1'b1);
    end_pattern("t2b", 1'b0, 1'b0);

    // 3: short pattern with ignored capture-phase strobes
    pat = 16'h0167;
    e = sig_of(16'h0000, pat, 9);
    arm(20'd10, e);
    for (int i = 0; i < 9; i++) begin
      shift(pat[i], 1'b1);
      if (i % 3 == 2) shift(1'b1, 1'b0);
    end
    chk("t3_bit_cnt", 32'(bit_cnt), 32'd9);
    end_pattern("t3", 1'b0, 1'b0);

    // 4: watchdog with no progress
    arm(20'd0, 16'h0000);
    repeat (15) step();
    chk("t4_pre_timeout", 32'(timeout), 32'd0);
    chk("t4_pre_busy", 32'(busy), 32'd1);
    push_expect(1'b1);
    step();
    chk("t4_timeout", 32'(timeout), 32'd1);
    chk("t4_check_rv", 32'(result_valid), 32'd0);
    step();
    collect("t4");

    // ScanNum=0, no bits, matching signature
    arm(20'd0, 16'h0000);
    end_pattern("zero", 1'b0, 1'b0);

    // scan_done already high at arm: no edge until it drops and rises again
    scan_done = 1'b1;
    step();
    arm(20'd0, 16'h0000);
    repeat (3) step();
    chk("stale_done_rv", 32'(result_valid), 32'd0);
    chk("stale_done_busy", 32'(busy), 32'd1);
    scan_done = 1'b0;
    step();
    end_pattern("stale", 1'b0, 1'b0);

    // 5: re-arm mid-shift discards the pattern
    arm(20'd5, 16'h0000);
    for (int i = 0; i < 5; i++) shift(1'b1, 1'b1);
    pat = 16'h000B;
    e = sig_of(16'h0000, pat, 4);
    arm(20'd4, e);
    chk("t5_sig", 32'(sig), 32'h0);
    chk("t5_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("t5_rv", 32'(result_valid), 32'd0);
    chk("t5_def_sig", 32'(d_sig), 32'hFFFF);
    for (int i = 0; i < 4; i++) shift(pat[i], 1'b1);
    end_pattern("t5", 1'b0, 1'b0);

    // 6: reset mid-shift, then final bit coincident with scan_done
    arm(20'd3, 16'h1234);
    shift(1'b1, 1'b1);
    shift(1'b0, 1'b1);
    rst = 1'b1;
    step();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sig", 32'(sig), 32'h0);
    chk("t6_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("t6_flags", {29'd0, pass, cnt_err, timeout}, 32'd0);
    chk("t6_rv", 32'(result_valid), 32'd0);
    chk("t6_def_sig", 32'(d_sig), 32'hFFFF);
    chk("t6_def_rest", {d_bit_cnt, 7'd0, d_busy, d_result_valid, d_pass, d_cnt_err, d_timeout}, 32'd0);
    rst = 1'b0;
    test_se = 1'b0;
    step();
    pat = 16'h0005;
    e = sig_of(16'h0000, pat, 3);
    arm(20'd3, e);
    shift(pat[0], 1'b1);
    shift(pat[1], 1'b1);
    end_pattern("t6", 1'b1, pat[2]);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
